cp0_exc_ctrl: RTL and testbench

Coprocessor-0 exception/interrupt controller at the M stage of the 5-stage MIPS pipeline. It consumes the exception code, branch-delay flag and victim PC that the pipeline registers carry forward. It raises the single-cycle `req` that flushes the pipeline registers and redirects fetch to 0x0000_4180. It holds SR/Cause/EPC for `mfc0`/`mtc0`/`eret`.

---
 rtl/cp0_exc_ctrl.sv | 100 ++++++++++
 tb/tb_cp0_exc_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller at the M stage.
// Holds SR/Cause/EPC and raises the pipeline flush request.
module cp0_exc_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rd_addr,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        wr_en,
    input  logic [31:0] vpc,
    input  logic        bd,
    input  logic [4:0]  exc_code,
    input  logic [5:0]  hw_int,
    input  logic        eret,
    output logic [31:0] rd_data,
    output logic [31:0] epc_out,
    output logic [31:0] handler_pc,
    output logic        req
);

    localparam logic [31:0] PRID = 32'h4C5A_5131;

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic [4:0]  code;
    logic [31:0] vpc_adj;
    logic        wr_sr;
    logic        wr_epc;

    assign int_req = (|(hw_int & sr_im)) & sr_ie & ~sr_exl;
    assign exc_req = (exc_code != 5'd0) & ~sr_exl;
    assign req     = int_req | exc_req;
    // interrupts outrank synchronous exceptions
    assign code    = int_req ? 5'd0 : exc_code;
    // a delay-slot victim restarts at its branch
    assign vpc_adj = bd ? (vpc - 32'd4) : vpc;

    assign wr_sr  = wr_en & ~req & (wr_addr == 5'd12);
    assign wr_epc = wr_en & ~req & (wr_addr == 5'd14);

    assign epc_out    = epc;
    assign handler_pc = HANDLER_ADDR;

    // CP0 state: exception entry beats mtc0/eret; eret clears EXL last
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            cause_ip <= hw_int;
            if (req) begin
                sr_exl    <= 1'b1;
                cause_bd  <= bd;
                cause_exc <= code;
                epc       <= {vpc_adj[31:2], 2'b00};
            end else begin
                if (wr_sr) begin
                    sr_im  <= wr_data[15:10];
                    sr_exl <= wr_data[1];
                    sr_ie  <= wr_data[0];
                end
                if (wr_epc) begin
                    epc <= {wr_data[31:2], 2'b00};
                end
                if (eret) begin
                    sr_exl <= 1'b0;
                end
            end
        end
    end

    // mfc0 read port, shows pre-edge register contents
    always_comb begin
        rd_data = '0;
        case (rd_addr)
            5'd12: rd_data = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
            5'd13: rd_data = {cause_bd, 15'd0, cause_ip, 3'd0,
                              cause_exc, 2'b00};
            5'd14: rd_data = epc;
            5'd15: rd_data = PRID;
            default: rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: directed scenarios
// plus random traffic against a word-level CP0 model.
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rd_addr;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_en;
    logic [31:0] vpc;
    logic        bd;
    logic [4:0]  exc_code;
    logic [5:0]  hw_int;
    logic        eret;
    logic [31:0] rd_data;
    logic [31:0] epc_out;
    logic [31:0] handler_pc;
    logic        req;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] m_sr, m_cause, m_epc;

    cp0_exc_ctrl dut (
        .clk(clk), .reset(reset),
        .rd_addr(rd_addr), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_en(wr_en),
        .vpc(vpc), .bd(bd), .exc_code(exc_code),
        .hw_int(hw_int), .eret(eret),
        .rd_data(rd_data), .epc_out(epc_out),
        .handler_pc(handler_pc), .req(req)
    );

    always #5 clk = ~clk;

    function automatic logic m_int();
        return ((hw_int & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_req();
        return m_int() || (exc_code != 5'd0 && !m_sr[1]);
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        case (a)
            5'd12: return m_sr;
            5'd13: return m_cause;
            5'd14: return m_epc;
            5'd15: return 32'h4C5A_5131;
            default: return 32'd0;
        endcase
    endfunction

    // one clock edge; the model advances from the pre-edge inputs
    task automatic tick();
        logic [31:0] ns, nc, ne;
        ns = m_sr; nc = m_cause; ne = m_epc;
        nc[15:10] = hw_int;
        if (m_req()) begin
            ns[1] = 1'b1;
            nc[31] = bd;
            nc[6:2] = m_int() ? 5'd0 : exc_code;
            ne = (bd ? vpc - 32'd4 : vpc) & 32'hFFFF_FFFC;
        end else begin
            if (wr_en && wr_addr == 5'd12) ns = wr_data & 32'h0000_FC03;
            if (wr_en && wr_addr == 5'd14) ne = wr_data & 32'hFFFF_FFFC;
            if (eret) ns[1] = 1'b0;
        end
        if (reset) begin
            ns = 0; nc = 0; ne = 0;
        end
        @(posedge clk);
        m_sr = ns; m_cause = nc; m_epc = ne;
        #1;
    endtask

    task automatic idle();
        reset = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
        vpc = 32'h3000; bd = 0; exc_code = 0; hw_int = 0; eret = 0;
    endtask

    task automatic test_reset();
        logic [31:0] exp [4];
        exp = '{32'd0, 32'd0, 32'd0, 32'h4C5A_5131};
        idle();
        reset = 1; rd_addr = 12;
        tick(); tick();
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            rd_addr = 5'(12 + i); #1;
            n_chk++;
            if (rd_data !== exp[i]) begin
                n_fail++;
                $display("FAIL reset_rd%0d: got %h want %h",
                         12 + i, rd_data, exp[i]);
            end
        end
        n_chk++;
        if (req !== 1'b0 || epc_out !== 0) begin
            n_fail++;
            $display("FAIL reset_out: req %b epc %h want 0", req, epc_out);
        end
        n_chk++;
        if (handler_pc !== 32'h0000_4180) begin
            n_fail++;
            $display("FAIL handler_pc: got %h want 00004180", handler_pc);
        end
    endtask

    task automatic test_exception();
        exc_code = 12; vpc = 32'h3010; bd = 0; #1;
        n_chk++;
        if (req !== 1'b1) begin
            n_fail++; $display("FAIL exc_req: got %b want 1", req);
        end
        tick();
        exc_code = 4; rd_addr = 13; #1;
        n_chk++;
        if (rd_data !== 32'h30) begin
            n_fail++; $display("FAIL exc_cause: got %h want 30", rd_data);
        end
        n_chk++;
        if (epc_out !== 32'h3010) begin
            n_fail++; $display("FAIL exc_epc: got %h want 3010", epc_out);
        end
        rd_addr = 12; #1;
        n_chk++;
        if (rd_data !== 32'h2) begin
            n_fail++; $display("FAIL exc_exl: got %h want 2", rd_data);
        end
        n_chk++;
        if (req !== 1'b0) begin
            n_fail++; $display("FAIL exl_mask: got %b want 0", req);
        end
        exc_code = 0;
    endtask

    task automatic test_interrupt_bd();
        wr_en = 1; wr_addr = 12; wr_data = 32'h401;
        tick();
        wr_en = 0;
        hw_int = 6'b000001; exc_code = 4; bd = 1; vpc = 32'h3024; #1;
        n_chk++;
        if (req !== 1'b1) begin
            n_fail++; $display("FAIL int_req: got %b want 1", req);
        end
        tick();
        exc_code = 0; bd = 0; rd_addr = 13; #1;
        n_chk++;
        if (rd_data !== 32'h8000_0400) begin
            n_fail++;
            $display("FAIL int_cause: got %h want 80000400", rd_data);
        end
        n_chk++;
        if (epc_out !== 32'h3020) begin
            n_fail++; $display("FAIL int_epc: got %h want 3020", epc_out);
        end
    endtask

    task automatic test_eret();
        eret = 1; #1;
        n_chk++;
        if (req !== 1'b0) begin
            n_fail++; $display("FAIL eret_masked: got %b want 0", req);
        end
        tick();
        eret = 0; rd_addr = 12; vpc = 32'h3040; #1;
        n_chk++;
        if (rd_data !== 32'h401) begin
            n_fail++; $display("FAIL eret_sr: got %h want 401", rd_data);
        end
        n_chk++;
        if (req !== 1'b1) begin
            n_fail++; $display("FAIL eret_pending: got %b want 1", req);
        end
        tick();
        hw_int = 0; #1;
        n_chk++;
        if (epc_out !== 32'h3040) begin
            n_fail++; $display("FAIL pend_epc: got %h want 3040", epc_out);
        end
    endtask

    task automatic test_req_vs_write();
        wr_en = 1; wr_addr = 12; wr_data = 32'h400;
        tick();
        wr_addr = 14; wr_data = 32'h5000;
        exc_code = 10; vpc = 32'h3100; bd = 0;
        tick();
        wr_en = 0; exc_code = 0; rd_addr = 13; #1;
        n_chk++;
        if (epc_out !== 32'h3100) begin
            n_fail++; $display("FAIL drop_wr: got %h want 3100", epc_out);
        end
        n_chk++;
        if (rd_data !== 32'h28) begin
            n_fail++; $display("FAIL drop_cause: got %h want 28", rd_data);
        end
    endtask

    task automatic test_corners();
        wr_en = 1; wr_addr = 13; wr_data = 32'hFFFF_FFFF;
        tick();
        wr_addr = 14; wr_data = 32'h3007;
        tick();
        wr_en = 0; rd_addr = 13; #1;
        n_chk++;
        if (rd_data !== 32'h28) begin
            n_fail++; $display("FAIL cause_ro: got %h want 28", rd_data);
        end
        n_chk++;
        if (epc_out !== 32'h3004) begin
            n_fail++; $display("FAIL epc_wr: got %h want 3004", epc_out);
        end
        // eret together with an SR write that sets EXL
        wr_en = 1; wr_addr = 12; wr_data = 32'h403; eret = 1;
        tick();
        wr_en = 0; eret = 0; rd_addr = 12; #1;
        n_chk++;
        if (rd_data !== 32'h401) begin
            n_fail++; $display("FAIL eret_wr: got %h want 401", rd_data);
        end
        // req together with eret keeps EXL set
        exc_code = 3; eret = 1; vpc = 32'h3200;
        tick();
        exc_code = 0; eret = 0; #1;
        n_chk++;
        if (rd_data !== 32'h403) begin
            n_fail++; $display("FAIL req_eret: got %h want 403", rd_data);
        end
        eret = 1;
        tick();
        eret = 0; exc_code = 1; bd = 1; vpc = 32'h0;
        tick();
        exc_code = 0; bd = 0; #1;
        n_chk++;
        if (epc_out !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL bd_wrap: got %h want fffffffc", epc_out);
        end
        reset = 1;
        tick();
        reset = 0; #1;
        n_chk++;
        if (epc_out !== 0 || rd_data !== 0) begin
            n_fail++;
            $display("FAIL mid_reset: epc %h sr %h want 0", epc_out, rd_data);
        end
    endtask

    task automatic test_random();
        logic [4:0] addrs [6];
        addrs = '{5'd12, 5'd13, 5'd14, 5'd15, 5'd0, 5'd20};
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(63) == 0);
            wr_en    = ($urandom_range(3) == 0);
            wr_addr  = addrs[$urandom_range(5)];
            wr_data  = $urandom;
            rd_addr  = addrs[$urandom_range(5)];
            vpc      = $urandom;
            bd       = $urandom_range(1);
            exc_code = ($urandom_range(3) == 0) ? 5'($urandom) : 5'd0;
            hw_int   = ($urandom_range(1) == 0) ? 6'($urandom) : 6'd0;
            eret     = ($urandom_range(3) == 0);
            #1;
            n_chk++;
            if (req !== m_req()) begin
                n_fail++;
                $display("FAIL rnd_req[%0d]: got %b want %b", i, req, m_req());
            end
            n_chk++;
            if (rd_data !== m_rd(rd_addr)) begin
                n_fail++;
                $display("FAIL rnd_rd[%0d] a%0d: got %h want %h",
                         i, rd_addr, rd_data, m_rd(rd_addr));
            end
            n_chk++;
            if (epc_out !== m_epc) begin
                n_fail++;
                $display("FAIL rnd_epc[%0d]: got %h want %h", i, epc_out, m_epc);
            end
            tick();
        end
    endtask

    initial begin
        m_sr = 0; m_cause = 0; m_epc = 0;
        rd_addr = 0;
        idle();
        @(negedge clk);
        test_reset();
        test_exception();
        test_interrupt_bd();
        test_eret();
        test_req_vs_write();
        test_corners();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
